// File: rtl/pipe_execute_stage_if.sv
// Execute-stage bus: decode-side stage inputs, hazard controls, forwarding
// outputs and the E->M pipeline register contents.
interface pipe_execute_stage_if #(
   parameter int unsigned W = 64
);
   logic [2:0]   E_stat;
   logic [3:0]   E_icode;
   logic [3:0]   E_ifun;
   logic [W-1:0] E_valA;
   logic [W-1:0] E_valB;
   logic [W-1:0] E_valC;
   logic [3:0]   E_dstE;
   logic [3:0]   E_dstM;
   logic         m_exc;
   logic         W_exc;
   logic         M_stall;
   logic         M_bubble;

   logic [W-1:0] e_valE;
   logic [3:0]   e_dstE;
   logic         e_Cnd;
   logic         cc_zf;
   logic         cc_sf;
   logic         cc_of;
   logic [2:0]   M_stat;
   logic [3:0]   M_icode;
   logic         M_Cnd;
   logic [W-1:0] M_valE;
   logic [W-1:0] M_valA;
   logic [3:0]   M_dstE;
   logic [3:0]   M_dstM;

   modport master (
      output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
      output m_exc, W_exc, M_stall, M_bubble,
      input  e_valE, e_dstE, e_Cnd, cc_zf, cc_sf, cc_of,
      input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
   );

   modport slave (
      input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
      input  m_exc, W_exc, M_stall, M_bubble,
      output e_valE, e_dstE, e_Cnd, cc_zf, cc_sf, cc_of,
      output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
   );
endinterface

// File: rtl/pipe_execute_stage.sv
// Pipelined Y86-64 execute stage: ALU, condition-code register, branch/cmov
// condition and the E->M pipeline register with stall/bubble control.
module pipe_execute_stage #(
   parameter int unsigned W    = 64,
   parameter int unsigned STEP = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_execute_stage_if.slave bus
);
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [W-1:0] STEP_POS = W'(STEP);
   localparam logic [W-1:0] STEP_NEG = W'(0) - W'(STEP);

   logic [W-1:0] aluA;
   logic [W-1:0] aluB;
   logic [W-1:0] aluRes;
   logic [1:0]   aluFun;
   logic         aluOf;
   logic         ccZf;
   logic         ccSf;
   logic         ccOf;
   logic         ccLoad;
   logic         condMet;
   logic         execCnd;
   logic [3:0]   execDstE;

   logic [2:0]   mStat;
   logic [3:0]   mIcode;
   logic         mCnd;
   logic [W-1:0] mValE;
   logic [W-1:0] mValA;
   logic [3:0]   mDstE;
   logic [3:0]   mDstM;

   // Operand selection by instruction class.
   always_comb begin
      aluA = '0;
      aluB = '0;
      case (bus.E_icode)
         I_RRMOVQ, I_OPQ:              aluA = bus.E_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: aluA = bus.E_valC;
         I_CALL, I_PUSHQ:              aluA = STEP_NEG;
         I_RET, I_POPQ:                aluA = STEP_POS;
         default:                      aluA = '0;
      endcase
      case (bus.E_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: aluB = bus.E_valB;
         default:                                                   aluB = '0;
      endcase
   end

   // ALU and the overflow flag of the current result.
   always_comb begin
      aluFun = (bus.E_icode == I_OPQ) ? bus.E_ifun[1:0] : 2'd0;
      aluRes = '0;
      aluOf  = 1'b0;
      case (aluFun)
         2'd0: begin
            aluRes = aluB + aluA;
            aluOf  = (aluA[W-1] == aluB[W-1]) && (aluRes[W-1] != aluA[W-1]);
         end
         2'd1: begin
            aluRes = aluB - aluA;
            aluOf  = (aluA[W-1] != aluB[W-1]) && (aluRes[W-1] != aluB[W-1]);
         end
         2'd2:    aluRes = aluA & aluB;
         default: aluRes = aluA ^ aluB;
      endcase
   end

   // Condition evaluation against the architectural (pre-update) CC.
   always_comb begin
      condMet = 1'b0;
      case (bus.E_ifun)
         4'd0:    condMet = 1'b1;
         4'd1:    condMet = (ccSf ^ ccOf) | ccZf;
         4'd2:    condMet = ccSf ^ ccOf;
         4'd3:    condMet = ccZf;
         4'd4:    condMet = !ccZf;
         4'd5:    condMet = !(ccSf ^ ccOf);
         4'd6:    condMet = !(ccSf ^ ccOf) && !ccZf;
         default: condMet = 1'b0;
      endcase
      execCnd  = (bus.E_icode == I_RRMOVQ || bus.E_icode == I_JXX) ? condMet : 1'b1;
      execDstE = (bus.E_icode == I_RRMOVQ && !execCnd) ? R_NONE : bus.E_dstE;
   end

   assign ccLoad = (bus.E_icode == I_OPQ) && (bus.E_stat == STAT_AOK) &&
                   !bus.m_exc && !bus.W_exc && !bus.M_stall;

   // Condition-code register; a later-stage exception or a stall freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccZf <= 1'b1;
         ccSf <= 1'b0;
         ccOf <= 1'b0;
      end else if (ccLoad) begin
         ccZf <= (aluRes == '0);
         ccSf <= aluRes[W-1];
         ccOf <= aluOf;
      end
   end

   // E->M pipeline register: stall beats bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mStat  <= STAT_AOK;
         mIcode <= I_NOP;
         mCnd   <= 1'b0;
         mValE  <= '0;
         mValA  <= '0;
         mDstE  <= R_NONE;
         mDstM  <= R_NONE;
      end else if (bus.M_stall) begin
         mStat  <= mStat;
         mIcode <= mIcode;
         mCnd   <= mCnd;
         mValE  <= mValE;
         mValA  <= mValA;
         mDstE  <= mDstE;
         mDstM  <= mDstM;
      end else if (bus.M_bubble) begin
         mStat  <= STAT_AOK;
         mIcode <= I_NOP;
         mCnd   <= 1'b0;
         mValE  <= '0;
         mValA  <= '0;
         mDstE  <= R_NONE;
         mDstM  <= R_NONE;
      end else begin
         mStat  <= bus.E_stat;
         mIcode <= bus.E_icode;
         mCnd   <= execCnd;
         mValE  <= aluRes;
         mValA  <= bus.E_valA;
         mDstE  <= execDstE;
         mDstM  <= bus.E_dstM;
      end
   end

   assign bus.e_valE  = aluRes;
   assign bus.e_dstE  = execDstE;
   assign bus.e_Cnd   = execCnd;
   assign bus.cc_zf   = ccZf;
   assign bus.cc_sf   = ccSf;
   assign bus.cc_of   = ccOf;
   assign bus.M_stat  = mStat;
   assign bus.M_icode = mIcode;
   assign bus.M_Cnd   = mCnd;
   assign bus.M_valE  = mValE;
   assign bus.M_valA  = mValA;
   assign bus.M_dstE  = mDstE;
   assign bus.M_dstM  = mDstM;
endmodule

// File: tb/tb_pipe_execute_stage.sv
// Self-checking bench for pipe_execute_stage: directed scenarios plus a
// randomized run against a behavioural execute-stage model (W=64 and W=32).
module tb_pipe_execute_stage;
   logic clk;
   logic clkEn;
   logic rst_n;
   int   nTests;
   int   nFail;

   pipe_execute_stage_if #(.W(64)) ifc64 ();
   pipe_execute_stage_if #(.W(32)) ifc32 ();

   pipe_execute_stage #(.W(64), .STEP(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(ifc64));
   pipe_execute_stage #(.W(32), .STEP(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(ifc32));

   initial clk = 1'b0;
   always #5 clk = clkEn ? ~clk : 1'b0;

   // model state (64-bit instance)
   logic        mZf, mSf, mOf;
   logic [2:0]  eStat;
   logic [3:0]  eIcode, eDstE, eDstM;
   logic        eCnd;
   logic [63:0] eValE, eValA;
   // model combinational predictions
   logic [63:0] xValE;
   logic        xZf, xSf, xOf, xCnd;
   logic [3:0]  xDstE;

   task automatic model_alu(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                            output logic [63:0] r, output logic z, output logic s, output logic o);
      logic [63:0] a, b;
      logic [64:0] wide;
      case (ic)
         4'd2, 4'd6:       a = va;
         4'd3, 4'd4, 4'd5: a = vc;
         4'd8, 4'd10:      a = 64'd0 - 64'd8;
         4'd9, 4'd11:      a = 64'd8;
         default:          a = 64'd0;
      endcase
      case (ic)
         4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: b = vb;
         default:                                    b = 64'd0;
      endcase
      o = 1'b0;
      case ((ic == 4'd6) ? fn[1:0] : 2'd0)
         2'd0: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; o = wide[64] != wide[63]; end
         2'd1: begin wide = {b[63], b} - {a[63], a}; r = wide[63:0]; o = wide[64] != wide[63]; end
         2'd2: r = a & b;
         default: r = a ^ b;
      endcase
      z = (r == 64'd0);
      s = r[63];
   endtask

   function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic z, input logic s, input logic o);
      logic lt;
      if (ic != 4'd2 && ic != 4'd7) return 1'b1;
      lt = s ^ o;
      case (fn)
         4'd0: return 1'b1;
         4'd1: return lt | z;
         4'd2: return lt;
         4'd3: return z;
         4'd4: return !z;
         4'd5: return !lt;
         4'd6: return !lt && !z;
         default: return 1'b0;
      endcase
   endfunction

   task automatic predict();
      model_alu(ifc64.E_icode, ifc64.E_ifun, ifc64.E_valA, ifc64.E_valB, ifc64.E_valC,
                xValE, xZf, xSf, xOf);
      xCnd  = model_cnd(ifc64.E_icode, ifc64.E_ifun, mZf, mSf, mOf);
      xDstE = (ifc64.E_icode == 4'd2 && !xCnd) ? 4'hF : ifc64.E_dstE;
   endtask

   task automatic model_reset();
      mZf = 1'b1; mSf = 1'b0; mOf = 1'b0;
      eStat = 3'd1; eIcode = 4'd1; eCnd = 1'b0; eValE = '0; eValA = '0;
      eDstE = 4'hF; eDstM = 4'hF;
   endtask

   // Advance one clock edge and the model alongside it.
   task automatic clock_cycle();
      logic upd;
      predict();
      upd = (ifc64.E_icode == 4'd6) && (ifc64.E_stat == 3'd1) && !ifc64.m_exc &&
            !ifc64.W_exc && !ifc64.M_stall;
      @(posedge clk);
      if (upd) begin mZf = xZf; mSf = xSf; mOf = xOf; end
      if (ifc64.M_stall) begin
      end else if (ifc64.M_bubble) begin
         eStat = 3'd1; eIcode = 4'd1; eCnd = 1'b0; eValE = '0; eValA = '0;
         eDstE = 4'hF; eDstM = 4'hF;
      end else begin
         eStat = ifc64.E_stat; eIcode = ifc64.E_icode; eCnd = xCnd; eValE = xValE;
         eValA = ifc64.E_valA; eDstE = xDstE; eDstM = ifc64.E_dstM;
      end
      #1;
   endtask

   task automatic drive64(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                          input logic [63:0] vb, input logic [63:0] vc,
                          input logic [3:0] de, input logic [3:0] dm);
      ifc64.E_stat = 3'd1; ifc64.E_icode = ic; ifc64.E_ifun = fn;
      ifc64.E_valA = va; ifc64.E_valB = vb; ifc64.E_valC = vc;
      ifc64.E_dstE = de; ifc64.E_dstM = dm;
      ifc64.m_exc = 1'b0; ifc64.W_exc = 1'b0; ifc64.M_stall = 1'b0; ifc64.M_bubble = 1'b0;
   endtask

   task automatic drive32(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] va,
                          input logic [31:0] vb);
      ifc32.E_stat = 3'd1; ifc32.E_icode = ic; ifc32.E_ifun = fn;
      ifc32.E_valA = va; ifc32.E_valB = vb; ifc32.E_valC = '0;
      ifc32.E_dstE = 4'h1; ifc32.E_dstM = 4'hF;
      ifc32.m_exc = 1'b0; ifc32.W_exc = 1'b0; ifc32.M_stall = 1'b0; ifc32.M_bubble = 1'b0;
   endtask

   task automatic test_reset();
      clkEn = 1'b0; rst_n = 1'b1;
      drive64(4'd1, 4'd0, '0, '0, '0, 4'hF, 4'hF);
      drive32(4'd1, 4'd0, '0, '0);
      #2 rst_n = 1'b0;
      #2;
      nTests++; if (ifc64.M_icode !== 4'd1) begin nFail++; $display("FAIL rst_M_icode got %h exp 1", ifc64.M_icode); end
      nTests++; if (ifc64.M_dstE !== 4'hF) begin nFail++; $display("FAIL rst_M_dstE got %h exp f", ifc64.M_dstE); end
      nTests++; if (ifc64.M_stat !== 3'd1) begin nFail++; $display("FAIL rst_M_stat got %h exp 1", ifc64.M_stat); end
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b100) begin nFail++; $display("FAIL rst_cc got %b exp 100", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
      model_reset();
      #1 rst_n = 1'b1;
      #1 clkEn = 1'b1;
      clock_cycle();
      nTests++; if (ifc64.M_icode !== 4'd1) begin nFail++; $display("FAIL nop_M_icode got %h exp 1", ifc64.M_icode); end
      nTests++; if (ifc64.M_dstE !== 4'hF || ifc64.M_dstM !== 4'hF) begin nFail++; $display("FAIL nop_M_dst got %h/%h exp f/f", ifc64.M_dstE, ifc64.M_dstM); end
      nTests++; if (ifc64.M_valE !== 64'd0) begin nFail++; $display("FAIL nop_M_valE got %h exp 0", ifc64.M_valE); end
   endtask

   task automatic test_add_overflow();
      drive64(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h2, 4'hF);
      #1;
      nTests++; if (ifc64.e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin nFail++; $display("FAIL add_e_valE got %h exp fffffffffffffffe", ifc64.e_valE); end
      clock_cycle();
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b011) begin nFail++; $display("FAIL add_cc got %b exp 011", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
      nTests++; if (ifc64.M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin nFail++; $display("FAIL add_M_valE got %h exp fffffffffffffffe", ifc64.M_valE); end
   endtask

   task automatic test_sub_cmov();
      drive64(4'd6, 4'd1, 64'd5, 64'd5, '0, 4'h2, 4'hF);
      clock_cycle();
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b100) begin nFail++; $display("FAIL sub_cc got %b exp 100", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
      drive64(4'd2, 4'd1, 64'h55, '0, '0, 4'h3, 4'hF);
      #1;
      nTests++; if (ifc64.e_Cnd !== 1'b1) begin nFail++; $display("FAIL cmovle_e_Cnd got %b exp 1", ifc64.e_Cnd); end
      clock_cycle();
      nTests++; if (ifc64.M_dstE !== 4'h3 || ifc64.M_valE !== 64'h55) begin nFail++; $display("FAIL cmovle_M got dstE %h valE %h exp 3/55", ifc64.M_dstE, ifc64.M_valE); end
      drive64(4'd2, 4'd2, 64'h55, '0, '0, 4'h3, 4'hF);
      #1;
      nTests++; if (ifc64.e_Cnd !== 1'b0 || ifc64.e_dstE !== 4'hF) begin nFail++; $display("FAIL cmovl_e got Cnd %b dstE %h exp 0/f", ifc64.e_Cnd, ifc64.e_dstE); end
      clock_cycle();
      nTests++; if (ifc64.M_dstE !== 4'hF || ifc64.M_Cnd !== 1'b0) begin nFail++; $display("FAIL cmovl_M got dstE %h Cnd %b exp f/0", ifc64.M_dstE, ifc64.M_Cnd); end
   endtask

   task automatic test_stack();
      drive64(4'd10, 4'd0, 64'h1234, 64'h100, '0, 4'h4, 4'hF);
      clock_cycle();
      nTests++; if (ifc64.M_valE !== 64'hF8) begin nFail++; $display("FAIL push_M_valE got %h exp f8", ifc64.M_valE); end
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b100) begin nFail++; $display("FAIL push_cc got %b exp 100", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
      drive64(4'd11, 4'd0, 64'hF8, 64'hF8, '0, 4'h4, 4'h5);
      clock_cycle();
      nTests++; if (ifc64.M_valE !== 64'h100) begin nFail++; $display("FAIL pop_M_valE got %h exp 100", ifc64.M_valE); end
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b100) begin nFail++; $display("FAIL pop_cc got %b exp 100", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
   endtask

   task automatic test_exc_gating();
      drive64(4'd6, 4'd0, 64'd1, 64'd1, '0, 4'h2, 4'hF);
      clock_cycle();
      drive64(4'd6, 4'd3, '0, '0, '0, 4'h2, 4'hF);
      ifc64.m_exc = 1'b1;
      clock_cycle();
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b000) begin nFail++; $display("FAIL mexc_cc got %b exp 000", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
      nTests++; if (ifc64.M_valE !== 64'd0) begin nFail++; $display("FAIL mexc_M_valE got %h exp 0", ifc64.M_valE); end
      drive64(4'd6, 4'd3, '0, '0, '0, 4'h2, 4'hF);
      ifc64.W_exc = 1'b1;
      clock_cycle();
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b000) begin nFail++; $display("FAIL wexc_cc got %b exp 000", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
   endtask

   task automatic test_stall_bubble();
      drive64(4'd6, 4'd0, 64'd1, 64'd1, '0, 4'h4, 4'h6);
      clock_cycle();
      drive64(4'd6, 4'd3, '0, '0, '0, 4'h7, 4'h8);
      ifc64.M_stall = 1'b1; ifc64.M_bubble = 1'b1;
      clock_cycle();
      nTests++; if (ifc64.M_valE !== 64'd2 || ifc64.M_icode !== 4'd6 || ifc64.M_dstE !== 4'h4 || ifc64.M_dstM !== 4'h6) begin nFail++; $display("FAIL stall_M got valE %h icode %h dstE %h dstM %h exp 2/6/4/6", ifc64.M_valE, ifc64.M_icode, ifc64.M_dstE, ifc64.M_dstM); end
      nTests++; if (ifc64.cc_zf !== 1'b0) begin nFail++; $display("FAIL stall_cc_zf got %b exp 0", ifc64.cc_zf); end
      ifc64.M_stall = 1'b0;
      clock_cycle();
      nTests++; if (ifc64.M_icode !== 4'd1 || ifc64.M_dstE !== 4'hF || ifc64.M_valE !== 64'd0 || ifc64.M_Cnd !== 1'b0) begin nFail++; $display("FAIL bubble_M got icode %h dstE %h valE %h Cnd %b exp 1/f/0/0", ifc64.M_icode, ifc64.M_dstE, ifc64.M_valE, ifc64.M_Cnd); end
      nTests++; if (ifc64.cc_zf !== 1'b1) begin nFail++; $display("FAIL bubble_cc_zf got %b exp 1", ifc64.cc_zf); end
   endtask

   task automatic test_w32();
      drive64(4'd1, 4'd0, '0, '0, '0, 4'hF, 4'hF);
      drive32(4'd6, 4'd0, 32'h7FFF_FFFF, 32'h1);
      #1;
      nTests++; if (ifc32.e_valE !== 32'h8000_0000) begin nFail++; $display("FAIL w32_e_valE got %h exp 80000000", ifc32.e_valE); end
      clock_cycle();
      nTests++; if ({ifc32.cc_zf, ifc32.cc_sf, ifc32.cc_of} !== 3'b011) begin nFail++; $display("FAIL w32_cc got %b exp 011", {ifc32.cc_zf, ifc32.cc_sf, ifc32.cc_of}); end
      nTests++; if (ifc32.M_valE !== 32'h8000_0000) begin nFail++; $display("FAIL w32_M_valE got %h exp 80000000", ifc32.M_valE); end
      drive32(4'd1, 4'd0, '0, '0);
   endtask

   task automatic test_random();
      logic [63:0] va, vb;
      for (int i = 0; i < 400; i++) begin
         va = {$urandom, $urandom};
         vb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) vb = va;
         if ($urandom_range(0, 3) == 0) va = 64'($urandom_range(0, 20));
         drive64(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), va, vb,
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 4) == 0) ifc64.E_icode = 4'd6;
         if ($urandom_range(0, 4) == 0) ifc64.E_stat = 3'($urandom_range(1, 4));
         ifc64.m_exc    = ($urandom_range(0, 9) == 0);
         ifc64.W_exc    = ($urandom_range(0, 9) == 0);
         ifc64.M_stall  = ($urandom_range(0, 7) == 0);
         ifc64.M_bubble = ($urandom_range(0, 7) == 0);
         #1;
         predict();
         nTests++; if (ifc64.e_valE !== xValE) begin nFail++; $display("FAIL rnd%0d_e_valE got %h exp %h", i, ifc64.e_valE, xValE); end
         nTests++; if (ifc64.e_dstE !== xDstE || ifc64.e_Cnd !== xCnd) begin nFail++; $display("FAIL rnd%0d_e_fwd got %h/%b exp %h/%b", i, ifc64.e_dstE, ifc64.e_Cnd, xDstE, xCnd); end
         clock_cycle();
         nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== {mZf, mSf, mOf}) begin nFail++; $display("FAIL rnd%0d_cc got %b exp %b", i, {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}, {mZf, mSf, mOf}); end
         nTests++; if (ifc64.M_stat !== eStat || ifc64.M_icode !== eIcode || ifc64.M_Cnd !== eCnd) begin nFail++; $display("FAIL rnd%0d_M_ctl got %h/%h/%b exp %h/%h/%b", i, ifc64.M_stat, ifc64.M_icode, ifc64.M_Cnd, eStat, eIcode, eCnd); end
         nTests++; if (ifc64.M_valE !== eValE || ifc64.M_valA !== eValA) begin nFail++; $display("FAIL rnd%0d_M_val got %h/%h exp %h/%h", i, ifc64.M_valE, ifc64.M_valA, eValE, eValA); end
         nTests++; if (ifc64.M_dstE !== eDstE || ifc64.M_dstM !== eDstM) begin nFail++; $display("FAIL rnd%0d_M_dst got %h/%h exp %h/%h", i, ifc64.M_dstE, ifc64.M_dstM, eDstE, eDstM); end
      end
   endtask

   task automatic test_async_reset();
      drive64(4'd6, 4'd0, 64'd7, 64'hF000_0000_0000_0000, '0, 4'h2, 4'h3);
      clock_cycle();
      rst_n = 1'b0;
      #1;
      nTests++; if (ifc64.M_icode !== 4'd1 || ifc64.M_dstE !== 4'hF || ifc64.M_valE !== 64'd0) begin nFail++; $display("FAIL arst_M got icode %h dstE %h valE %h exp 1/f/0", ifc64.M_icode, ifc64.M_dstE, ifc64.M_valE); end
      nTests++; if ({ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of} !== 3'b100) begin nFail++; $display("FAIL arst_cc got %b exp 100", {ifc64.cc_zf, ifc64.cc_sf, ifc64.cc_of}); end
      model_reset();
      #1 rst_n = 1'b1;
      drive64(4'd6, 4'd0, 64'd2, 64'd3, '0, 4'h2, 4'hF);
      clock_cycle();
      nTests++; if (ifc64.M_valE !== 64'd5 || ifc64.M_icode !== 4'd6) begin nFail++; $display("FAIL arst_first_edge got valE %h icode %h exp 5/6", ifc64.M_valE, ifc64.M_icode); end
   endtask

   initial begin
      nTests = 0;
      nFail  = 0;
      test_reset();
      test_add_overflow();
      test_sub_cmov();
      test_stack();
      test_exc_gating();
      test_stall_bubble();
      test_w32();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pipe_execute_stage.md
Name: pipe_execute_stage

Overview:
Parametrised, pipelined successor to the single-cycle Y86-64 execute logic. Selects ALU operands from icode, computes valE, and holds condition codes in an architectural CC register, updated only by OPq. Evaluates the jXX/cmovXX condition (Cnd) and registers all results into the E->M pipeline register, with stall/bubble control from the hazard unit. Also drives same-cycle forwarding outputs (e_valE, e_dstE) for the decode stage.

Parameters:
W, 64, datapath width in bits (>= 16, multiple of 8)
STEP, 8, stack-pointer adjust magnitude in bytes for call/ret/push/pop

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
E_stat  in  3  stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
E_icode  in  4  instruction code
E_ifun  in  4  function code
E_valA  in  W  operand A
E_valB  in  W  operand B
E_valC  in  W  constant
E_dstE  in  4  ALU destination register (0xF = none)
E_dstM  in  4  memory destination register
m_exc  in  1  memory stage raises exception this cycle
W_exc  in  1  writeback stage holds exception
M_stall  in  1  hold E->M register
M_bubble  in  1  load nop into E->M register
e_valE  out  W  combinational ALU result (forwarding)
e_dstE  out  4  combinational effective dstE (forwarding)
e_Cnd  out  1  combinational condition result
cc_zf, cc_sf, cc_of  out  1 each  CC register contents
M_stat  out  3  registered stat
M_icode  out  4  registered icode
M_Cnd  out  1  registered Cnd
M_valE  out  W  registered ALU result
M_valA  out  W  registered valA (pass-through)
M_dstE  out  4  registered effective dstE
M_dstM  out  4  registered dstM

Behaviour:
- Operand A: icode 2,6 -> valA; 3,4,5 -> valC; 8,10 -> -STEP; 9,11 -> +STEP; else 0.
- Operand B: icode 4,5,6,8,9,10,11 -> valB; 2,3 -> 0; else 0.
- ALU function: ifun[1:0] when icode==6, else add. 0 add A+B, 1 sub B-A, 2 and, 3 xor. All results mod 2^W.
- Flags from the current ALU result, not a stale register: ZF = (result==0); SF = result[W-1]; OF add = (A[W-1]==B[W-1]) & (R[W-1]!=A[W-1]); OF sub = (A[W-1]!=B[W-1]) & (R[W-1]!=B[W-1]); OF and/xor = 0.
- CC update at the clock edge iff icode==6 & E_stat==AOK & !m_exc & !W_exc & !M_stall. Otherwise hold.
- Cnd uses the CC register (pre-update value). ifun: 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF), 6 g !(SF^OF)&!ZF, 7-15 -> 0. e_Cnd is meaningful for icode 2 and 7 and is forced 1 for all other icodes.
- e_dstE = 0xF when icode==2 & !e_Cnd, else E_dstE.
- E->M register priority: rst_n low > M_stall (hold all) > M_bubble (load bubble) > load stage values. M_stall wins over M_bubble when both are asserted.
- Bubble/reset value: stat=1, icode=1, Cnd=0, valE=0, valA=0, dstE=0xF, dstM=0xF.
- CC reset: ZF=1, SF=0, OF=0.
- Latency: e_* outputs are combinational (0 cycles). M_* outputs take 1 cycle.
- Asynchronous reset mid-stream clears M_* and CC immediately, with no clock needed. The first edge after rst_n rises loads normally.

Test Plan:
- Reset: assert rst_n=0 with no clk -> M_icode=1, M_dstE=0xF, cc={ZF1,SF0,OF0}. Release, apply nop -> same bubble values propagate.
- OPq add overflow, W=64: valA=valB=0x7FFF_FFFF_FFFF_FFFF, ifun 0 -> e_valE=0xFFFF_FFFF_FFFF_FFFE. After the edge, cc={ZF0,SF1,OF1} and M_valE matches.
- Sub equal then cmovle: subq valA=5,valB=5 -> ZF=1. Next rrmovq ifun 1, dstE=3 -> e_Cnd=1, M_dstE=3. Then cmovl ifun 2 -> e_Cnd=0, M_dstE=0xF.
- Stack adjust: pushq valB=0x100 -> M_valE=0xF8. popq valB=0xF8 -> M_valE=0x100. CC unchanged in both cases.
- Exception gating: OPq xor 0^0 with m_exc=1 -> CC holds its prior value, M_valE=0. Repeat with W_exc=1 -> CC holds.
- Stall/bubble: M_stall=1 & M_bubble=1 with OPq -> M_* and CC hold. M_bubble only -> bubble values are loaded and CC still updates. Rerun the add test with W=32 (0x7FFFFFFF+1) -> OF=1, SF=1.
